// File: rtl/multi_dev_bridge.sv
`default_nettype none
// ============================================================================
// Module   : multi_dev_bridge
// Purpose  : Routes CPU M-stage accesses to data memory or to NDEV memory-mapped
//            peripheral slots, stalling the CPU while a slot handshakes.
//            Optional macro BRIDGE_TIMEOUT_EN adds a WAIT timeout with bus_err.
// Revision : 1.0 - initial release
// ============================================================================
module multi_dev_bridge #(
    parameter int          NDEV     = 2,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
    parameter int          TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_byteen,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_stall,
    output logic [31:0]          dm_addr,
    output logic [31:0]          dm_wdata,
    output logic [3:0]           dm_byteen,
    input  logic [31:0]          dm_rdata,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [NDEV-1:0]      dev_sel,
    output logic                 dev_we,
    input  logic [NDEV*32-1:0]   dev_rdata,
    input  logic [NDEV-1:0]      dev_ready,
    output logic                 bus_err
);

    localparam int          c_IW       = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [31:0] c_WIN_SIZE = 32'(16 * NDEV);

    generate
        if (NDEV < 1 || NDEV > 8 || TIMEOUT < 1) begin : g_bad_params
            $error("multi_dev_bridge: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state_q,  w_state_d;
    logic [31:0]     r_addr_q,   w_addr_d;
    logic [31:0]     r_wdata_q,  w_wdata_d;
    logic [3:0]      r_byteen_q, w_byteen_d;
    logic [c_IW-1:0] r_idx_q,    w_idx_d;
    logic [31:0]     r_rdata_q,  w_rdata_d;

    logic [31:0] w_offset;
    logic        w_in_win;
    logic        w_hit;
    logic        w_ready;
    logic [31:0] w_slot_rdata;
    logic        w_timeout;

    // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
    assign w_offset     = cpu_addr - DEV_BASE;
    assign w_in_win     = (w_offset < c_WIN_SIZE);
    assign w_hit        = w_in_win && (w_offset[3:2] != 2'b11);
    assign w_ready      = dev_ready[r_idx_q];
    assign w_slot_rdata = dev_rdata[32*r_idx_q +: 32];

`ifdef BRIDGE_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);

    logic [c_TW-1:0] r_cnt_q, w_cnt_d;
    logic            r_bus_err_q, w_bus_err_d;

    // Counter is held at zero outside WAIT, so it is clear on every WAIT entry.
    assign w_cnt_d     = (r_state_q == S_WAIT) ? r_cnt_q + 1'b1 : '0;
    assign w_timeout   = (r_cnt_q == c_TW'(TIMEOUT - 1));
    assign w_bus_err_d = (r_state_q == S_WAIT) && !w_ready && w_timeout;
    assign bus_err     = r_bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q     <= '0;
            r_bus_err_q <= 1'b0;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_bus_err_q <= w_bus_err_d;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_byteen_d = r_byteen_q;
        w_idx_d    = r_idx_q;
        w_rdata_d  = r_rdata_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_hit) begin
                    w_addr_d   = cpu_addr;
                    w_wdata_d  = cpu_wdata;
                    w_byteen_d = cpu_byteen;
                    w_idx_d    = w_offset[c_IW+3:4];
                    w_state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ready) begin
                    w_rdata_d = w_slot_rdata;
                    w_state_d = S_DONE;
                end else if (w_timeout) begin
                    w_rdata_d = 32'h0;
                    w_state_d = S_DONE;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_addr_q   <= 32'h0;
            r_wdata_q  <= 32'h0;
            r_byteen_q <= 4'h0;
            r_idx_q    <= '0;
            r_rdata_q  <= 32'h0;
        end else begin
            r_state_q  <= w_state_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_byteen_q <= w_byteen_d;
            r_idx_q    <= w_idx_d;
            r_rdata_q  <= w_rdata_d;
        end
    end

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = dm_rdata;
        dm_byteen = cpu_byteen;
        dev_sel   = '0;
        dev_we    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_in_win) begin
                    dm_byteen = 4'h0;
                    cpu_rdata = 32'h0;
                    cpu_stall = w_hit;
                end
            end
            S_WAIT: begin
                cpu_stall = 1'b1;
                dm_byteen = 4'h0;
                cpu_rdata = 32'h0;
                dev_sel   = NDEV'(1) << r_idx_q;
                dev_we    = |r_byteen_q;
            end
            S_DONE: begin
                cpu_rdata = r_rdata_q;
                if (w_in_win) begin
                    dm_byteen = 4'h0;
                end
            end
            default: ;
        endcase
    end

    assign dm_addr   = cpu_addr;
    assign dm_wdata  = cpu_wdata;
    assign dev_addr  = r_addr_q;
    assign dev_wdata = r_wdata_q;

endmodule
`default_nettype wire

// File: doc/multi_dev_bridge.md
MULTI_DEV_BRIDGE -- requirements
Module: multi_dev_bridge

Interface
REQ-001 SHALL have parameter NDEV, default 2, meaning number of peripheral slots (1..8).
REQ-002 SHALL have parameter DEV_BASE, default 32'h0000_7F00, meaning the first slot's base address; slot k base = DEV_BASE + 16*k.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the WAIT-cycle limit (used only under REQ-024).
REQ-004 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cpu_addr in 32, cpu_wdata in 32 and cpu_byteen in 4: CPU store/load address, store data and store byte enables (all-zero = read).
REQ-007 SHALL have ports cpu_rdata out 32 (load data to CPU) and cpu_stall out 1 (freeze CPU M stage).
REQ-008 SHALL have ports dm_addr out 32, dm_wdata out 32, dm_byteen out 4 and dm_rdata in 32: data-memory side.
REQ-009 SHALL have ports dev_addr out 32, dev_wdata out 32, dev_sel out NDEV, dev_we out 1, dev_rdata in NDEV*32 (slot k at bits 32k+31:32k) and dev_ready in NDEV.
REQ-010 SHALL have port bus_err out 1: one-cycle device-timeout pulse.

Function
REQ-011 SHALL decode a device hit when cpu_addr lies in [DEV_BASE, DEV_BASE+16*NDEV) with slot offset 0x0..0xB; slot index = (cpu_addr-DEV_BASE)>>4.
REQ-012 SHALL treat an address in that window with offset 0xC..0xF as a hole: dm_byteen=0, no dev_sel, cpu_rdata=0, no stall.
REQ-013 SHALL route all other addresses to DM combinationally: dm_addr/dm_wdata pass through, dm_byteen=cpu_byteen, cpu_rdata=dm_rdata, zero added latency.
REQ-014 SHALL force dm_byteen to 4'b0 in every cycle whose cpu_addr is in the device window.
REQ-015 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-016 IDLE: on device hit, assert cpu_stall that cycle, latch addr, wdata, byteen and slot index, and go to WAIT; otherwise remain in IDLE.
REQ-017 WAIT: drive dev_sel one-hot from latched index, dev_addr/dev_wdata from latches, dev_we = OR of latched byteen, cpu_stall=1.
REQ-018 WAIT: when dev_ready[idx]=1, capture that slot's dev_rdata into a read register and go to DONE; dev_ready of other slots is ignored.
REQ-019 DONE: cpu_stall=0, cpu_rdata = read register, dev_sel=0, no decode of cpu_addr; next state IDLE.
REQ-020 Minimum device access SHALL cost 2 stall cycles (IDLE, WAIT with ready=1) then DONE.
REQ-021 dev_sel SHALL be all-zero and dev_we 0 in IDLE and DONE; the peripheral sees exactly one write strobe per store.
REQ-022 Back-to-back device accesses SHALL each complete IDLE->WAIT->DONE; one DONE cycle separates them.

Reset
REQ-023 Synchronous reset SHALL force IDLE, cpu_stall=0, dev_sel=0, dev_we=0, bus_err=0 and clear the latches, read register and timeout counter; reset in WAIT abandons the access with no write strobe afterwards.

Configuration
REQ-024 With BRIDGE_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; on reaching TIMEOUT without ready it SHALL load 32'h0 into the read register, go to DONE and pulse bus_err=1 in that DONE cycle; the counter clears on entering WAIT.
REQ-025 Without BRIDGE_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL persist until ready, and bus_err SHALL be tied 0.

Verification
REQ-026 Store 0x1234 to 0x0000_0040, byteen 4'hF -> dm_byteen=4'hF same cycle, cpu_stall=0, dev_sel=0.
REQ-027 Store 0x5 to 0x7F10 (NDEV=2), dev_ready[1] high -> stall 2 cycles, dev_sel=2'b10 and dev_we=1 for 1 cycle, dm_byteen=0 throughout.
REQ-028 Load 0x7F04, dev_ready[0] delayed 3 cycles, dev_rdata slot0=0xABCD -> stall 4 cycles, cpu_rdata=0xABCD in DONE.
REQ-029 Load 0x7F0C (hole) -> cpu_rdata=0, no stall, dev_sel=0, dm_byteen=0.
REQ-030 BRIDGE_TIMEOUT_EN, TIMEOUT=16, load 0x7F00 with dev_ready=0 -> bus_err pulse after 16 WAIT cycles, cpu_rdata=0, FSM returns to IDLE.
REQ-031 Reset asserted in second WAIT cycle -> next cycle IDLE, cpu_stall=0, dev_sel=0, no later dev_we.
